demultiplier_inv: RTL and testbench

Iterative unsigned restoring divider: the inverse of the pipelined processing-element multiplier. It takes a double-width dividend (typically a product) and a single-width divisor, then produces quotient and remainder one bit per clock. It sits beside the multiplier in the PE datapath for normalisation and averaging. It uses the same `den` stall convention as the multiplier.

---
 rtl/demultiplier_inv.sv | 157 +++++++++++++++
 tb/tb_demultiplier_inv.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demultiplier_inv.sv
// demultiplier_inv: iterative unsigned restoring divider, one quotient bit per clock.
// Divides a double-width dividend by a single-width divisor.
// Ports:
//   clk, reset      - rising-edge clock, asynchronous active-high reset
//   den             - stall: all registers hold while high
//   start           - request a division (accepted in IDLE or DONE when den=0)
//   data_in_a       - OUTPUT_WIDTH-bit dividend
//   data_in_b       - INPUT_WIDTH-bit divisor
//   quotient        - OUTPUT_WIDTH-bit result, held until the next result
//   remainder       - INPUT_WIDTH-bit result, held until the next result
//   busy            - high while an iteration sequence is in flight
//   div_out_valid   - one-cycle pulse (stretched by den) when results update
//   div_by_zero     - qualifies the held result as a divide-by-zero
module demultiplier_inv #(
  parameter int unsigned INPUT_WIDTH  = 16,
  parameter int unsigned OUTPUT_WIDTH = INPUT_WIDTH * 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    den,
  input  logic                    start,
  input  logic [OUTPUT_WIDTH-1:0] data_in_a,
  input  logic [INPUT_WIDTH-1:0]  data_in_b,
  output logic [OUTPUT_WIDTH-1:0] quotient,
  output logic [INPUT_WIDTH-1:0]  remainder,
  output logic                    busy,
  output logic                    div_out_valid,
  output logic                    div_by_zero
);

  localparam int unsigned IW    = INPUT_WIDTH;
  localparam int unsigned OW    = OUTPUT_WIDTH;
  localparam int unsigned CNT_W = $clog2(OW + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OW-1:0]    work_q, work_d;     // dividend shifts out the top, quotient bits shift in
  logic [IW-1:0]    divisor_q, divisor_d;
  logic [IW:0]      prem_q, prem_d;     // partial remainder
  logic [OW-1:0]    quot_q, quot_d;
  logic [IW-1:0]    rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             dbz_q, dbz_d;

  // One restoring step: shift in the dividend MSB, trial-subtract the divisor.
  logic [IW+1:0] shifted_c;
  logic          ge_c;
  logic [IW:0]   diff_c;

  always_comb begin
    shifted_c = {prem_q, work_q[OW-1]};
    ge_c      = (shifted_c >= (IW+2)'(divisor_q));
    // Only used when ge_c, where the true difference is below the divisor and fits.
    diff_c    = shifted_c[IW:0] - {1'b0, divisor_q};
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      prem_q    <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      prem_q    <= prem_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      dbz_q     <= dbz_d;
    end
  end

  // Next-state and registered-output logic; den=1 leaves every register unchanged.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    prem_d    = prem_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    dbz_d     = dbz_q;

    if (!den) begin
      valid_d = 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          if (start) begin
            if (data_in_b == '0) begin
              // Divide by zero resolves immediately without iterating.
              state_d = S_DONE;
              quot_d  = '1;
              rem_d   = data_in_a[IW-1:0];
              dbz_d   = 1'b1;
              valid_d = 1'b1;
            end else begin
              state_d   = S_RUN;
              busy_d    = 1'b1;
              work_d    = data_in_a;
              divisor_d = data_in_b;
              prem_d    = '0;
              cnt_d     = CNT_W'(OW);
            end
          end
        end

        S_RUN: begin
          work_d = {work_q[OW-2:0], ge_c};
          prem_d = ge_c ? diff_c : shifted_c[IW:0];
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            valid_d = 1'b1;
            quot_d  = {work_q[OW-2:0], ge_c};
            rem_d   = ge_c ? diff_c[IW-1:0] : shifted_c[IW-1:0];
            dbz_d   = 1'b0;
          end
        end

        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign quotient      = quot_q;
  assign remainder     = rem_q;
  assign busy          = busy_q;
  assign div_out_valid = valid_q;
  assign div_by_zero   = dbz_q;

endmodule

// File: tb/tb_demultiplier_inv.sv
// tb_demultiplier_inv: scoreboard bench for the restoring divider.
module tb_demultiplier_inv;

  localparam int unsigned IW = 16;
  localparam int unsigned OW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          den;
  logic          start;
  logic [OW-1:0] data_in_a;
  logic [IW-1:0] data_in_b;
  logic [OW-1:0] quotient;
  logic [IW-1:0] remainder;
  logic          busy;
  logic          div_out_valid;
  logic          div_by_zero;

  demultiplier_inv #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) dut (
    .clk          (clk),
    .reset        (reset),
    .den          (den),
    .start        (start),
    .data_in_a    (data_in_a),
    .data_in_b    (data_in_b),
    .quotient     (quotient),
    .remainder    (remainder),
    .busy         (busy),
    .div_out_valid(div_out_valid),
    .div_by_zero  (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OW-1:0] q;
    logic [IW-1:0] r;
    logic          dbz;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Drive a start request (at a negedge) and push the modelled result.
  task automatic issue(input logic [OW-1:0] a, input logic [IW-1:0] b);
    exp_t e;
    data_in_a = a;
    data_in_b = b;
    start     = 1'b1;
    if (b == '0) begin
      e.q = '1; e.r = a[IW-1:0]; e.dbz = 1'b1;
    end else begin
      e.q = a / OW'(b); e.r = IW'(a % OW'(b)); e.dbz = 1'b0;
    end
    sb.push_back(e);
  endtask

  // Step negedges until div_out_valid, optionally stalling or injecting a stray start.
  task automatic wait_valid(input int budget, input int stall_at, input int stall_len,
                            input int ign_at, output int cycles, output int busy_cycles,
                            output bit ok);
    cycles = 0; busy_cycles = 0; ok = 1'b0;
    while (cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) start = 1'b0;
      if (cycles == ign_at) begin
        start = 1'b1; data_in_a = 32'd999999; data_in_b = 16'd3;
      end
      if (ign_at > 0 && cycles == ign_at + 1) start = 1'b0;
      if (cycles == stall_at) den = 1'b1;
      if (stall_at > 0 && cycles == stall_at + stall_len) den = 1'b0;
      if (busy) busy_cycles++;
      if (div_out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int vcnt;
    reset = 1'b1; den = 1'b0; start = 1'b0; data_in_a = '0; data_in_b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if ({quotient, remainder, busy, div_out_valid, div_by_zero} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: q=%h r=%h busy=%b v=%b dbz=%b, all must be 0",
               quotient, remainder, busy, div_out_valid, div_by_zero);
    end
    vcnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (div_out_valid || busy) vcnt++;
    end
    n_tests++;
    if (vcnt !== 0) begin
      n_fail++;
      $display("FAIL reset_idle: %0d cycles with valid/busy, expected 0", vcnt);
    end
  endtask

  task automatic test_basic;
    int cyc, bc; bit ok; exp_t e;
    issue(32'd1000, 16'd7);
    wait_valid(40, -1, 0, -1, cyc, bc, ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || cyc !== 33) begin
      n_fail++; $display("FAIL basic_latency: got %0d (seen=%0b), expected 33", cyc, ok);
    end
    n_tests++;
    if (bc !== 32) begin
      n_fail++; $display("FAIL basic_busy: busy for %0d cycles, expected 32", bc);
    end
    n_tests++;
    if (quotient !== e.q || quotient !== 32'd142) begin
      n_fail++; $display("FAIL basic_q: got %0d, expected %0d", quotient, e.q);
    end
    n_tests++;
    if (remainder !== e.r || div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL basic_r: got r=%0d dbz=%b, expected r=%0d dbz=0",
                         remainder, div_by_zero, e.r);
    end
    @(negedge clk);
    n_tests++;
    if (div_out_valid !== 1'b0 || quotient !== 32'd142) begin
      n_fail++; $display("FAIL basic_pulse: v=%b q=%0d, expected v=0 q=142",
                         div_out_valid, quotient);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, bc; bit ok; exp_t e;
    issue(32'hFFFE0001, 16'hFFFF);
    wait_valid(40, -1, 0, -1, cyc, bc, ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || quotient !== 32'h0000FFFF || remainder !== 16'h0 || quotient !== e.q) begin
      n_fail++; $display("FAIL inverse_result: q=%h r=%h seen=%0b, expected q=0000ffff r=0",
                         quotient, remainder, ok);
    end
    issue(32'd5, 16'd9);   // driven in the DONE cycle
    wait_valid(40, -1, 0, -1, cyc, bc, ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || cyc !== 33) begin
      n_fail++; $display("FAIL b2b_latency: got %0d (seen=%0b), expected 33", cyc, ok);
    end
    n_tests++;
    if (quotient !== e.q || remainder !== e.r || remainder !== 16'd5) begin
      n_fail++; $display("FAIL b2b_result: q=%0d r=%0d, expected q=%0d r=%0d",
                         quotient, remainder, e.q, e.r);
    end
  endtask

  task automatic test_div_by_zero;
    int cyc, bc; bit ok; exp_t e;
    issue(32'h12345678, 16'd0);
    wait_valid(5, -1, 0, -1, cyc, bc, ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || cyc !== 1) begin
      n_fail++; $display("FAIL dbz_latency: got %0d (seen=%0b), expected 1", cyc, ok);
    end
    n_tests++;
    if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz ||
        remainder !== 16'h5678) begin
      n_fail++; $display("FAIL dbz_result: q=%h r=%h dbz=%b, expected q=%h r=%h dbz=1",
                         quotient, remainder, div_by_zero, e.q, e.r);
    end
    @(negedge clk);
    n_tests++;
    if (div_out_valid !== 1'b0 || div_by_zero !== 1'b1) begin
      n_fail++; $display("FAIL dbz_hold: v=%b dbz=%b, expected v=0 dbz=1",
                         div_out_valid, div_by_zero);
    end
    issue(32'd100, 16'd10);
    wait_valid(40, -1, 0, -1, cyc, bc, ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || div_by_zero !== 1'b0 || quotient !== e.q || remainder !== e.r) begin
      n_fail++; $display("FAIL dbz_clear: q=%0d r=%0d dbz=%b, expected q=%0d r=%0d dbz=0",
                         quotient, remainder, div_by_zero, e.q, e.r);
    end
  endtask

  task automatic test_stall;
    int cyc, bc, held; bit ok; exp_t e; logic [OW-1:0] q0;
    issue(32'd123456789, 16'd1000);
    wait_valid(60, 10, 5, -1, cyc, bc, ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || cyc !== 38) begin
      n_fail++; $display("FAIL stall_latency: got %0d (seen=%0b), expected 38", cyc, ok);
    end
    n_tests++;
    if (quotient !== e.q || remainder !== e.r) begin
      n_fail++; $display("FAIL stall_result: q=%0d r=%0d, expected q=%0d r=%0d",
                         quotient, remainder, e.q, e.r);
    end
    q0 = quotient;
    den = 1'b1;
    held = 0;
    repeat (3) begin
      @(negedge clk);
      if (div_out_valid === 1'b1 && quotient === q0) held++;
    end
    n_tests++;
    if (held !== 3) begin
      n_fail++; $display("FAIL stall_valid_hold: valid held %0d of 3 stalled cycles", held);
    end
    den = 1'b0;
    @(negedge clk);
    n_tests++;
    if (div_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_valid_clear: v=%b, expected 0", div_out_valid);
    end
  endtask

  task automatic test_ignored_start;
    int cyc, bc, act; bit ok; exp_t e;
    issue(32'd50000, 16'd123);
    wait_valid(40, -1, 0, 10, cyc, bc, ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || cyc !== 33 || quotient !== e.q || remainder !== e.r) begin
      n_fail++; $display("FAIL ignore_start: cyc=%0d q=%0d r=%0d, expected cyc=33 q=%0d r=%0d",
                         cyc, quotient, remainder, e.q, e.r);
    end
    act = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || div_out_valid) act++;
    end
    n_tests++;
    if (act !== 0) begin
      n_fail++; $display("FAIL ignore_not_queued: %0d active cycles, expected 0", act);
    end
  endtask

  task automatic test_reset_abort;
    int cyc, bc, act; bit ok; exp_t e;
    issue(32'd1000000, 16'd77);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    #1;
    void'(sb.pop_back());
    n_tests++;
    if ({quotient, remainder, busy, div_out_valid, div_by_zero} !== '0) begin
      n_fail++; $display("FAIL abort_outputs: q=%0d r=%0d busy=%b v=%b, expected all 0",
                         quotient, remainder, busy, div_out_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    act = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || div_out_valid) act++;
    end
    n_tests++;
    if (act !== 0) begin
      n_fail++; $display("FAIL abort_no_valid: %0d active cycles, expected 0", act);
    end
    issue(32'd77777, 16'd13);
    wait_valid(40, -1, 0, -1, cyc, bc, ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || cyc !== 33 || quotient !== e.q || remainder !== e.r) begin
      n_fail++; $display("FAIL abort_next: cyc=%0d q=%0d r=%0d, expected cyc=33 q=%0d r=%0d",
                         cyc, quotient, remainder, e.q, e.r);
    end
  endtask

  task automatic test_random;
    int cyc, bc; bit ok; exp_t e;
    logic [OW-1:0] a; logic [IW-1:0] b;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = IW'($urandom_range(1, 65535));
      if (i == 0) b = 16'd1;
      if (i == 1) b = 16'hFFFF;
      if (i == 2) a = 32'hFFFFFFFF;
      issue(a, b);
      wait_valid(40, -1, 0, -1, cyc, bc, ok);
      e = sb.pop_front();
      n_tests++;
      if (!ok || cyc !== 33 || quotient !== e.q || remainder !== e.r || div_by_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL random_%0d: %h/%h cyc=%0d q=%h r=%h, expected cyc=33 q=%h r=%h",
                 i, a, b, cyc, quotient, remainder, e.q, e.r);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    @(negedge clk);
    test_basic();
    test_back_to_back();
    @(negedge clk);
    test_div_by_zero();
    @(negedge clk);
    test_stall();
    test_ignored_start();
    test_reset_abort();
    @(negedge clk);
    test_random();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
